pending_request_server: RTL and testbench
=========================================

# pending_request_server

Sequential front/back stage around the 4-bit highest-index priority encoder. Captures single-cycle request pulses into a pending register and drives that register onto the encoder inputs (P3..P0 → X3..X0). Takes the encoder's N1/N0/Z results back and issues one grant at a time, highest index first, over a valid/ready handshake. Clears each served bit, then enforces a fixed service interval before the next grant.

## Interface
- SERVICE_CYCLES, 3: busy cycles after each accepted grant; legal range 1..15.

- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous active-low reset
- REQ  in  4  request pulses; REQ[i]=1 sampled at an edge sets pending bit i
- P  out  4  pending vector, wired to encoder X3..X0
- N1, N0  in  1 each  encoder index of highest set bit of P
- Z  in  1  encoder zero flag (P==0)
- GV  out  1  grant valid
- GI  out  2  grant index
- GR  in  1  grant ready from consumer
- BUSY  out  1  high in SERVICE state
- OVF  out  1  sticky overrun flag (see Configuration)

## Operation
- Reset (async, RST_N=0): P=0, GV=0, GI=0, BUSY=0, OVF=0, state=IDLE, counter=0. Reset mid-grant or mid-service discards everything; no grant completes.
- Pending register: at every edge, P <= (P & ~clr) | REQ. clr is the one-hot of GI when a handshake completes, else 0. Set wins over clear on the same bit.
- States:
  - IDLE: if Z==0, latch GI<={N1,N0}, GV<=1, go OFFER. Else stay.
  - OFFER: GV=1, GI frozen even if higher-index requests arrive. Handshake = GV&GR at an edge; then clear P[GI], GV<=0, counter<=SERVICE_CYCLES-1, go SERVICE. Without GR, hold indefinitely.
  - SERVICE: BUSY=1. Decrement counter each edge. At counter==0 the next edge goes to IDLE.
- Encoder path is combinational. IDLE decisions use N1/N0/Z of the current P within the same cycle.
- OVF: set at an edge where REQ[i]=1, P[i]=1 and bit i is not being cleared that edge. Cleared only by reset.

## Timing
- REQ sampled at edge k with P=0 and state IDLE: P updates after edge k, GV=1 after edge k+1.
- Handshake at edge h: GV=0 and BUSY=1 after h. BUSY stays high for exactly SERVICE_CYCLES cycles and drops after edge h+SERVICE_CYCLES (IDLE).
- Earliest next grant: GV=1 after edge h+SERVICE_CYCLES+1.
- Throughput: one grant per SERVICE_CYCLES+2 cycles with GR held high.
- GR while GV=0 is ignored.

## Configuration
- PRS_OVF_EN defined: OVF logic compiled in, behaves as above.
- PRS_OVF_EN undefined: no overrun logic; OVF tied to 0 and the port is retained.

## Test plan
- Reset: assert RST_N=0 mid-OFFER with P=4'b1010 → P=0, GV=0, BUSY=0, OVF=0 immediately, without waiting for a clock.
- Priority order: REQ=4'b0101 one pulse at edge 0, GR=1 always → GV after edge 1 with GI=2. Handshake at edge 2 → P=4'b0001, BUSY for 3 cycles. GV again after edge 6 with GI=0, then P=0 and GV stays 0.
- Frozen offer: REQ=4'b0010 → GI=1 offered. With GR=0, pulse REQ=4'b1000 → GI stays 1, P=4'b1010. Raise GR → bit1 served; next grant is GI=3.
- Set-over-clear: during OFFER with GI=3, pulse REQ=4'b1000 on the handshake edge → P[3] stays 1, OVF stays 0, GI=3 granted again after service.
- Overrun (PRS_OVF_EN defined): REQ=4'b0100 twice while P[2]=1 and GR=0 → OVF=1 and stays 1 after service. Same stimulus without the macro → OVF=0.
- Idle hold: no REQ for 20 cycles → Z=1, GV=0, BUSY=0, P=0 throughout.

Source files
------------

// File: rtl/pending_request_server.sv
// Pending-request front end for an external 4-bit highest-index priority encoder; serves one grant at a time.
// Optional overrun flag compiled in when PRS_OVF_EN is defined; otherwise OVF is tied low.
module pending_request_server #(
  parameter int unsigned SERVICE_CYCLES = 3
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] REQ,
  output logic [3:0] P,
  input  logic       N1,
  input  logic       N0,
  input  logic       Z,
  output logic       GV,
  output logic [1:0] GI,
  input  logic       GR,
  output logic       BUSY,
  output logic       OVF
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OFFER   = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SERVICE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [1:0] gi_nxt;
  logic       handshake;
  logic [3:0] clr;

  assign handshake = (state == OFFER) && GR;
  assign clr       = handshake ? (4'b0001 << GI) : '0;

  // GV is exactly "in OFFER": it rises on the IDLE->OFFER edge and falls on the handshake edge.
  assign GV   = (state == OFFER);
  assign BUSY = (state == SERVICE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gi_nxt    = GI;
    case (state)
      IDLE: begin
        if (!Z) begin
          gi_nxt    = {N1, N0};
          state_nxt = OFFER;
        end
      end
      OFFER: begin
        if (GR) begin
          cnt_nxt   = CNT_LOAD;
          state_nxt = SERVICE;
        end
      end
      SERVICE: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      cnt   <= '0;
      GI    <= '0;
      P     <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      GI    <= gi_nxt;
      P     <= (P & ~clr) | REQ;
    end
  end

`ifdef PRS_OVF_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                    OVF <= 1'b0;
    else if (|(REQ & P & ~clr))    OVF <= 1'b1;
  end
`else
  assign OVF = 1'b0;
`endif

endmodule

// File: tb/tb_pending_request_server.sv
// Self-checking bench for pending_request_server: directed scenarios plus randomized traffic against a timeline model.
module tb_pending_request_server;

  localparam int SC = 3;
`ifdef PRS_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [3:0] REQ;
  logic [3:0] P;
  logic       N1, N0, Z;
  logic       GV;
  logic [1:0] GI;
  logic       GR;
  logic       BUSY;
  logic       OVF;

  int checks = 0;
  int errors = 0;

  // Reference model: pending bits, offered index (-1 = none), edge of last handshake.
  logic [3:0] m_pend;
  int         m_offer;
  int         m_last_hs;
  int         m_edge;
  logic       m_ovf;

  pending_request_server #(.SERVICE_CYCLES(SC)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .P(P),
    .N1(N1), .N0(N0), .Z(Z),
    .GV(GV), .GI(GI), .GR(GR), .BUSY(BUSY), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  // External highest-index priority encoder.
  always_comb begin
    Z = (P == 4'b0000);
    if      (P[3]) {N1, N0} = 2'd3;
    else if (P[2]) {N1, N0} = 2'd2;
    else if (P[1]) {N1, N0} = 2'd1;
    else           {N1, N0} = 2'd0;
  end

  function automatic int highest(input logic [3:0] v);
    for (int i = 3; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic exp_busy();
    return ((m_edge - 1 - m_last_hs) < SC) ? 1'b1 : 1'b0;
  endfunction

  task automatic model_reset();
    m_pend    = '0;
    m_offer   = -1;
    m_last_hs = -1000;
    m_edge    = 0;
    m_ovf     = 1'b0;
  endtask

  task automatic apply_reset();
    REQ   = '0;
    GR    = 1'b0;
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    model_reset();
  endtask

  // Drive one cycle of inputs, advance the model across the edge, settle past the edge.
  task automatic step(input logic [3:0] r, input logic g);
    logic [3:0] clr;
    logic       hs;
    REQ = r;
    GR  = g;
    @(posedge CLK);
    hs  = (m_offer >= 0) && g;
    clr = hs ? (4'b0001 << m_offer) : 4'b0000;
    if (|(r & m_pend & ~clr)) m_ovf = 1'b1;
    if (hs) begin
      m_last_hs = m_edge;
      m_offer   = -1;
    end else if (m_offer < 0 && m_edge >= m_last_hs + SC + 1 && m_pend != 4'b0000) begin
      m_offer = highest(m_pend);
    end
    m_pend = (m_pend & ~clr) | r;
    m_edge++;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    step(4'b0010, 1'b0);
    step(4'b1000, 1'b0);
    step(4'b0000, 1'b0);
    checks++;
    if (GV !== 1'b1 || P !== 4'b1010) begin
      errors++;
      $display("FAIL reset_setup GV=%b P=%b expected GV=1 P=1010", GV, P);
    end
    #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if (P !== 4'b0000 || GV !== 1'b0 || BUSY !== 1'b0 || OVF !== 1'b0) begin
      errors++;
      $display("FAIL reset_async P=%b GV=%b BUSY=%b OVF=%b expected all zero", P, GV, BUSY, OVF);
    end
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, 1'b1);
      checks++;
      if (GV !== 1'b0 || BUSY !== 1'b0 || P !== 4'b0000) begin
        errors++;
        $display("FAIL reset_after GV=%b BUSY=%b P=%b expected 0 0 0000", GV, BUSY, P);
      end
    end
  endtask

  task automatic test_priority();
    apply_reset();
    step(4'b0101, 1'b1);
    checks++;
    if (P !== 4'b0101 || GV !== 1'b0) begin
      errors++;
      $display("FAIL prio_capture P=%b GV=%b expected 0101 0", P, GV);
    end
    step(4'b0000, 1'b1);
    checks++;
    if (GV !== 1'b1 || GI !== 2'd2) begin
      errors++;
      $display("FAIL prio_first GV=%b GI=%0d expected 1 2", GV, GI);
    end
    step(4'b0000, 1'b1);
    checks++;
    if (P !== 4'b0001 || GV !== 1'b0 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL prio_handshake P=%b GV=%b BUSY=%b expected 0001 0 1", P, GV, BUSY);
    end
    for (int i = 0; i < SC - 1; i++) begin
      step(4'b0000, 1'b1);
      checks++;
      if (BUSY !== 1'b1 || GV !== 1'b0) begin
        errors++;
        $display("FAIL prio_busy BUSY=%b GV=%b expected 1 0", BUSY, GV);
      end
    end
    step(4'b0000, 1'b1);
    checks++;
    if (BUSY !== 1'b0 || GV !== 1'b0) begin
      errors++;
      $display("FAIL prio_idle BUSY=%b GV=%b expected 0 0", BUSY, GV);
    end
    step(4'b0000, 1'b1);
    checks++;
    if (GV !== 1'b1 || GI !== 2'd0) begin
      errors++;
      $display("FAIL prio_second GV=%b GI=%0d expected 1 0", GV, GI);
    end
    step(4'b0000, 1'b1);
    checks++;
    if (P !== 4'b0000 || GV !== 1'b0) begin
      errors++;
      $display("FAIL prio_drain P=%b GV=%b expected 0000 0", P, GV);
    end
    for (int i = 0; i < 8; i++) begin
      step(4'b0000, 1'b1);
      checks++;
      if (GV !== 1'b0) begin
        errors++;
        $display("FAIL prio_quiet GV=%b expected 0", GV);
      end
    end
  endtask

  task automatic test_frozen_offer();
    apply_reset();
    step(4'b0010, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b1000, 1'b0);
    checks++;
    if (GV !== 1'b1 || GI !== 2'd1 || P !== 4'b1010) begin
      errors++;
      $display("FAIL frozen_hold GV=%b GI=%0d P=%b expected 1 1 1010", GV, GI, P);
    end
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b1);
    checks++;
    if (P !== 4'b1000 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL frozen_serve P=%b BUSY=%b expected 1000 1", P, BUSY);
    end
    for (int i = 0; i < SC; i++) step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    checks++;
    if (GV !== 1'b1 || GI !== 2'd3) begin
      errors++;
      $display("FAIL frozen_next GV=%b GI=%0d expected 1 3", GV, GI);
    end
  endtask

  task automatic test_set_over_clear();
    apply_reset();
    step(4'b1000, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b1000, 1'b1);
    checks++;
    if (P !== 4'b1000 || OVF !== 1'b0 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL set_clear P=%b OVF=%b BUSY=%b expected 1000 0 1", P, OVF, BUSY);
    end
    for (int i = 0; i < SC; i++) step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    checks++;
    if (GV !== 1'b1 || GI !== 2'd3) begin
      errors++;
      $display("FAIL set_clear_regrant GV=%b GI=%0d expected 1 3", GV, GI);
    end
    step(4'b0000, 1'b1);
    checks++;
    if (P !== 4'b0000) begin
      errors++;
      $display("FAIL set_clear_drain P=%b expected 0000", P);
    end
  endtask

  task automatic test_overrun();
    apply_reset();
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    checks++;
    if (OVF !== OVF_ON || GV !== 1'b1 || GI !== 2'd2) begin
      errors++;
      $display("FAIL overrun_set OVF=%b GV=%b GI=%0d expected %b 1 2", OVF, GV, GI, OVF_ON);
    end
    step(4'b0000, 1'b1);
    for (int i = 0; i < SC + 1; i++) step(4'b0000, 1'b0);
    checks++;
    if (OVF !== OVF_ON || P !== 4'b0000 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL overrun_sticky OVF=%b P=%b BUSY=%b expected %b 0000 0", OVF, P, BUSY, OVF_ON);
    end
  endtask

  task automatic test_idle_hold();
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      step(4'b0000, 1'b0);
      checks++;
      if (Z !== 1'b1 || GV !== 1'b0 || BUSY !== 1'b0 || P !== 4'b0000) begin
        errors++;
        $display("FAIL idle_hold Z=%b GV=%b BUSY=%b P=%b expected 1 0 0 0000", Z, GV, BUSY, P);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic       g;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      r = '0;
      for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 5) == 0);
      g = ($urandom_range(0, 2) != 0);
      step(r, g);
      checks++;
      if (P !== m_pend || GV !== (m_offer >= 0) || BUSY !== exp_busy() ||
          OVF !== (m_ovf & OVF_ON) || (m_offer >= 0 && GI !== 2'(m_offer))) begin
        errors++;
        $display("FAIL random_%0d P=%b GV=%b GI=%0d BUSY=%b OVF=%b expected P=%b GV=%b GI=%0d BUSY=%b OVF=%b",
                 i, P, GV, GI, BUSY, OVF, m_pend, (m_offer >= 0), m_offer, exp_busy(), m_ovf & OVF_ON);
      end
    end
  endtask

  initial begin
    RST_N = 1'b0;
    REQ   = '0;
    GR    = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    test_reset();
    test_priority();
    test_frozen_offer();
    test_set_over_clear();
    test_overrun();
    test_idle_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
